md_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined CPU. It sits beside the ALU in the E stage, takes operands from the E-stage bypass muxes, and holds results in HI/LO for later mfhi/mflo reads. Operations run for a configurable number of cycles, and `busy` drives the hazard unit's stall logic. A cancel input lets a later exception/flush stage abort an in-flight operation.

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_arith.sv | 79 +++++++
 rtl/md_unit.sv | 107 ++++++++++
 tb/tb_md_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state encoding and default latencies shared by the
// multiply/divide unit and its arithmetic core.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MSUB  = 3'd7;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_DEF_WIDTH       = 32;
    localparam int MD_DEF_MULT_CYCLES = 5;
    localparam int MD_DEF_DIV_CYCLES  = 10;

    function automatic int md_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for every op that occupies the unit for several cycles.
    function automatic logic md_is_multi(input logic [2:0] op, input logic madd_en);
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op) ||
               (madd_en && ((op == MD_MADD) || (op == MD_MSUB)));
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational result path of the multiply/divide unit, packing the
// 2*WIDTH result as {hi, lo}. MADD/MSUB exist only with MD_UNIT_MADD_EN.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = MD_DEF_WIDTH
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MD_UNIT_MADD_EN
    input  logic [2*WIDTH-1:0] acc,
`endif
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;

    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] b_safe_u;
    logic [WIDTH-1:0] b_safe_s;
    logic [WIDTH-1:0] quot_u;
    logic [WIDTH-1:0] rem_u;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);

    // The dividers never see a zero divisor or the overflowing pair; those
    // cases are overridden below, so the divider inputs stay well defined.
    assign b_safe_u = div_zero ? WIDTH'(1) : b;
    assign b_safe_s = (div_zero || div_ovf) ? WIDTH'(1) : b;

    assign quot_u = a / b_safe_u;
    assign rem_u  = a % b_safe_u;
    assign quot_s = $unsigned($signed(a) / $signed(b_safe_s));
    assign rem_s  = $unsigned($signed(a) % $signed(b_safe_s));

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)
                    result = {a, {WIDTH{1'b1}}};
                else if (div_ovf)
                    result = {{WIDTH{1'b0}}, a};
                else
                    result = {rem_s, quot_s};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {a, {WIDTH{1'b1}}};
                else
                    result = {rem_u, quot_u};
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD:  result = acc + prod_s;
            MD_MSUB:  result = acc - prod_s;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, busy/done
// handshake and cancel. Define MD_UNIT_MADD_EN to enable MADD/MSUB (op 6/7).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = MD_DEF_WIDTH,
    parameter int MULT_CYCLES = MD_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES)) + 1;

`ifdef MD_UNIT_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] result;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
`ifdef MD_UNIT_MADD_EN
        .acc    ({hi, lo}),
`endif
        .result (result)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        if (md_is_multi(op, MADD_EN)) begin
                            op_q  <= op;
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state <= MD_BUSY;
                            busy  <= 1'b1;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MD_BUSY: begin
                    // A flush on the commit edge wins: HI/LO keep their old values.
                    if (cancel) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= result;
                        state    <= MD_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against a 64-bit
// arithmetic reference model of HI/LO, busy and done.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam int INJ_NONE   = 0;
    localparam int INJ_START  = 1;
    localparam int INJ_CANCEL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            OP_MULT:  return sx * sy;
            OP_MULTU: return ux * uy;
            OP_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            OP_MADD:  return acc + sx * sy;
            OP_MSUB:  return acc - sx * sy;
            default:  return acc;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic mt(input logic [2:0] o, input logic [31:0] x);
        start = 1'b1; op = o; a = x;
        step();
        start = 1'b0; a = $urandom;
        if (o == OP_MTHI) m_hi = x; else m_lo = x;
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            errors++;
            $display("FAIL mt op%0d: busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=%h lo=%h",
                     o, busy, done, hi, lo, m_hi, m_lo);
        end
    endtask

    // Issues a multi-cycle op and checks every cycle until done (or cancel).
    // Returns in the cycle after commit/cancel, so the caller may issue again.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj_cycle, input int inj_kind, input string name);
        int n;
        logic [63:0] expv;
        bit cancelled;
        n = (o == OP_DIV || o == OP_DIVU) ? DIV_N : MULT_N;
        expv = model(o, x, y, {m_hi, m_lo});
        cancelled = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        for (int c = 1; c <= n; c++) begin
            checks++;
            if ({busy, done, hi, lo} !== {2'b10, m_hi, m_lo}) begin
                errors++;
                $display("FAIL %s cycle %0d: busy=%b done=%b hi=%h lo=%h, expected busy=1 done=0 hi=%h lo=%h",
                         name, c, busy, done, hi, lo, m_hi, m_lo);
            end
            if (c == inj_cycle && inj_kind == INJ_START) begin
                start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
            end
            if (c == inj_cycle && inj_kind == INJ_CANCEL) cancel = 1'b1;
            step();
            start = 1'b0;
            cancel = 1'b0;
            if (c == inj_cycle && inj_kind == INJ_CANCEL) begin
                cancelled = 1'b1;
                break;
            end
        end
        if (!cancelled) begin
            m_hi = expv[63:32];
            m_lo = expv[31:0];
        end
        checks++;
        if ({busy, done, hi, lo} !== {1'b0, ~cancelled, m_hi, m_lo}) begin
            errors++;
            $display("FAIL %s end: busy=%b done=%b hi=%h lo=%h, expected busy=0 done=%b hi=%h lo=%h",
                     name, busy, done, hi, lo, ~cancelled, m_hi, m_lo);
        end
    endtask

    task automatic check_quiet(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            step();
            checks++;
            if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin
                errors++;
                $display("FAIL %s idle %0d: busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=%h lo=%h",
                         name, i, busy, done, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic check_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_initial: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        #2 reset = 1'b0;
        step();
        mt(OP_MTLO, $urandom | 32'h1);
        mt(OP_MTHI, $urandom | 32'h1);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        step();
        mt(OP_MTLO, $urandom | 32'h1);
        start = 1'b1; op = OP_DIV; a = $urandom; b = 32'($urandom_range(1, 1000));
        step();
        start = 1'b0;
        step();
        step();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check_quiet(DIV_N + 2, "reset_no_done");
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, INJ_NONE, "mult_dir");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_dir_value");
        run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd7, 0, INJ_NONE, "multu_dir");
        check_hilo(32'h0000_0006, 32'hFFFF_FFEB, "multu_dir_value");
        for (int i = 0; i < 6; i++) begin
            run_op(($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU,
                   rnd_operand(), rnd_operand(), 0, INJ_NONE, "mult_rand");
        end
    endtask

    task automatic test_div();
        run_op(OP_DIVU, 32'd100, 32'd7, 0, INJ_NONE, "divu_dir");
        check_hilo(32'd2, 32'd14, "divu_dir_value");
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, INJ_NONE, "div_dir");
        check_hilo(32'hFFFF_FFFE, 32'hFFFF_FFF2, "div_dir_value");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, INJ_NONE, "div_ovf");
        check_hilo(32'h0, 32'h8000_0000, "div_ovf_value");
        run_op(OP_DIVU, 32'd5, 32'd0, 0, INJ_NONE, "divu_zero");
        check_hilo(32'd5, 32'hFFFF_FFFF, "divu_zero_value");
        run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, INJ_NONE, "div_zero");
        for (int i = 0; i < 8; i++) begin
            run_op(($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU,
                   rnd_operand(), rnd_operand(), 0, INJ_NONE, "div_rand");
        end
    endtask

    task automatic test_ignore_cancel();
        run_op(OP_DIV, $urandom, 32'($urandom_range(1, 500)), 3, INJ_START, "ignored_start");
        run_op(OP_DIV, $urandom, rnd_operand(), 3, INJ_CANCEL, "cancel_c3");
        check_quiet(DIV_N + 2, "cancel_c3_after");
        run_op(OP_MULT, $urandom, $urandom, MULT_N, INJ_CANCEL, "cancel_on_commit");
        check_quiet(MULT_N + 2, "cancel_on_commit_after");
        cancel = 1'b1;
        check_quiet(1, "cancel_idle");
        cancel = 1'b0;
        // Back-to-back: each call issues in the previous op's done cycle.
        run_op(OP_MULTU, $urandom, $urandom, 0, INJ_NONE, "b2b_first");
        run_op(OP_DIVU, $urandom, rnd_operand(), 0, INJ_NONE, "b2b_second");
        mt(OP_MTHI, $urandom);
    endtask

    task automatic test_accumulate();
        mt(OP_MTLO, 32'd10);
        mt(OP_MTHI, 32'd0);
        check_hilo(32'd0, 32'd10, "mt_value");
`ifdef MD_UNIT_MADD_EN
        run_op(OP_MADD, 32'd2, 32'd3, 0, INJ_NONE, "madd_dir");
        check_hilo(32'd0, 32'd16, "madd_dir_value");
        run_op(OP_MSUB, 32'd4, 32'd5, 0, INJ_NONE, "msub_dir");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFC, "msub_dir_value");
        for (int i = 0; i < 4; i++) begin
            run_op(($urandom_range(0, 1) == 0) ? OP_MADD : OP_MSUB,
                   rnd_operand(), rnd_operand(), 0, INJ_NONE, "macc_rand");
        end
`else
        start = 1'b1; op = OP_MADD; a = 32'd2; b = 32'd3;
        step();
        start = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, 32'd0, 32'd10}) begin
            errors++;
            $display("FAIL madd_disabled: busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=0 lo=10",
                     busy, done, hi, lo);
        end
        check_quiet(MULT_N + 1, "madd_disabled_after");
        start = 1'b1; op = OP_MSUB; a = 32'd4; b = 32'd5;
        step();
        start = 1'b0;
        check_quiet(MULT_N + 1, "msub_disabled_after");
`endif
    endtask

    task automatic test_back_to_back();
        int max_op;
`ifdef MD_UNIT_MADD_EN
        max_op = 7;
`else
        max_op = 5;
`endif
        for (int i = 0; i < 12; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, max_op));
            if (o == OP_MTHI || o == OP_MTLO)
                mt(o, $urandom);
            else
                run_op(o, rnd_operand(), rnd_operand(), 0, INJ_NONE, "b2b_rand");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore_cancel();
        test_accumulate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
